// File: rtl/motor_ramp_ctrl.sv
// motor_ramp_ctrl -- two-wheel duty ramp controller with direction reversal.
//
// A command carries a target duty and direction per wheel. The registered duty
// outputs move by one count per prescaler step until they reach the target.
// A wheel that must reverse first ramps down to zero, then its H-bridge direction
// is flipped, and then it ramps up again. estop forces both duties to zero at
// once and holds the block in BRAKE until estop is released.
//
// Build option: define MOTOR_RAMP_DWELL_EN to add the DWELL state. A reversing
// wheel then sits at zero duty for DWELL_STEPS ramp steps before its direction
// flips. If the macro is not defined, the direction flips on the first step tick
// at zero duty.
//
// Parameters
//   RAMP_DIV    clk_in cycles per ramp step (>= 2)
//   DWELL_STEPS ramp steps spent at zero duty before a flip (>= 1)
//   DUTY_MAX    ceiling applied to accepted targets (0..15)
// Ports
//   clk_in            sole clock, rising edge
//   reset             asynchronous, active-high
//   cmd_valid         command offered; held by the sender until cmd_ready
//   cmd_ready         command can be accepted this cycle
//   tgt_l, tgt_r      target duty per wheel (PWM counts)
//   tdir_l, tdir_r    target direction per wheel, 0 = forward
//   estop             emergency stop, level-sensitive, highest priority
//   duty_l, duty_r    registered duty to the PWM generators
//   dir_l, dir_r      registered H-bridge direction
//   busy              high in RAMP, DWELL or BRAKE
//   done              one-cycle pulse in the cycle a command settles
module motor_ramp_ctrl #(
    parameter int unsigned RAMP_DIV    = 1525,
    parameter int unsigned DWELL_STEPS = 8,
    parameter int unsigned DUTY_MAX    = 15
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] tgt_l,
    input  logic [3:0] tgt_r,
    input  logic       tdir_l,
    input  logic       tdir_r,
    input  logic       estop,
    output logic [3:0] duty_l,
    output logic [3:0] duty_r,
    output logic       dir_l,
    output logic       dir_r,
    output logic       busy,
    output logic       done
);

    if (RAMP_DIV < 2 || DWELL_STEPS < 1 || DUTY_MAX > 15) begin : g_param_check
        $error("motor_ramp_ctrl: parameter out of range");
    end

    localparam int unsigned PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(RAMP_DIV - 1);
    localparam logic [3:0] DUTY_CAP = 4'(DUTY_MAX);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RAMP  = 3'd1;
    localparam logic [2:0] ST_HOLD  = 3'd2;
    localparam logic [2:0] ST_BRAKE = 3'd3;
`ifdef MOTOR_RAMP_DWELL_EN
    localparam logic [2:0] ST_DWELL = 3'd4;
    localparam int unsigned DW = (DWELL_STEPS > 1) ? $clog2(DWELL_STEPS) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_STEPS - 1);

    logic [DW-1:0] dwell_cnt;
`endif

    logic [2:0]    state;
    logic [PW-1:0] pre_cnt;
    logic [3:0]    tgt_q_l, tgt_q_r;
    logic          tdir_q_l, tdir_q_r;

    logic          step_tick;
    logic          mis_l, mis_r;
    logic          zero_mis_l, zero_mis_r;
    logic          settled;
    logic          accept;
    logic [3:0]    sat_l, sat_r;

    // One ramp step: a wheel facing the wrong way only ever moves towards zero;
    // otherwise it moves one count towards its target. Never wraps.
    function automatic logic [3:0] step_duty(input logic [3:0] duty,
                                             input logic       mismatch,
                                             input logic [3:0] target);
        if (mismatch)
            return (duty != 4'd0) ? duty - 4'd1 : duty;
        else if (duty < target)
            return duty + 4'd1;
        else if (duty > target)
            return duty - 4'd1;
        else
            return duty;
    endfunction

    always_comb begin
        step_tick  = (pre_cnt == PRE_LAST);
        mis_l      = dir_l ^ tdir_q_l;
        mis_r      = dir_r ^ tdir_q_r;
        zero_mis_l = mis_l && (duty_l == 4'd0);
        zero_mis_r = mis_r && (duty_r == 4'd0);
        settled    = !mis_l && !mis_r && (duty_l == tgt_q_l) && (duty_r == tgt_q_r);
        cmd_ready  = ((state == ST_IDLE) || (state == ST_HOLD)) && !estop;
        accept     = cmd_valid && cmd_ready;
        busy       = (state == ST_RAMP) || (state == ST_BRAKE)
`ifdef MOTOR_RAMP_DWELL_EN
                     || (state == ST_DWELL)
`endif
                     ;
        // Settling is seen combinationally so done coincides with the RAMP exit.
        done       = (state == ST_RAMP) && settled && !estop;
        sat_l      = (tgt_l > DUTY_CAP) ? DUTY_CAP : tgt_l;
        sat_r      = (tgt_r > DUTY_CAP) ? DUTY_CAP : tgt_r;
    end

    // Free-running step prescaler, independent of the controller state.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset)
            pre_cnt <= '0;
        else if (step_tick)
            pre_cnt <= '0;
        else
            pre_cnt <= pre_cnt + PW'(1);
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            duty_l   <= '0;
            duty_r   <= '0;
            dir_l    <= 1'b0;
            dir_r    <= 1'b0;
            tgt_q_l  <= '0;
            tgt_q_r  <= '0;
            tdir_q_l <= 1'b0;
            tdir_q_r <= 1'b0;
`ifdef MOTOR_RAMP_DWELL_EN
            dwell_cnt <= '0;
`endif
        end else if (estop) begin
            // Directions are left alone so the bridge is not switched under load.
            state   <= ST_BRAKE;
            duty_l  <= '0;
            duty_r  <= '0;
            tgt_q_l <= '0;
            tgt_q_r <= '0;
`ifdef MOTOR_RAMP_DWELL_EN
            dwell_cnt <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_HOLD: begin
                    // Acceptance never moves a duty, even on a step tick.
                    if (accept) begin
                        tgt_q_l  <= sat_l;
                        tgt_q_r  <= sat_r;
                        tdir_q_l <= tdir_l;
                        tdir_q_r <= tdir_r;
                        state    <= ST_RAMP;
                    end
                end
                ST_RAMP: begin
`ifdef MOTOR_RAMP_DWELL_EN
                    if (zero_mis_l || zero_mis_r) begin
                        state     <= ST_DWELL;
                        dwell_cnt <= '0;
                    end else
`endif
                    if (settled) begin
                        state <= ((duty_l != 4'd0) || (duty_r != 4'd0)) ? ST_HOLD : ST_IDLE;
                    end else if (step_tick) begin
                        duty_l <= step_duty(duty_l, mis_l, tgt_q_l);
                        duty_r <= step_duty(duty_r, mis_r, tgt_q_r);
`ifndef MOTOR_RAMP_DWELL_EN
                        // Without a dwell the flip happens on the tick spent at zero.
                        if (zero_mis_l) dir_l <= tdir_q_l;
                        if (zero_mis_r) dir_r <= tdir_q_r;
`endif
                    end
                end
`ifdef MOTOR_RAMP_DWELL_EN
                ST_DWELL: begin
                    // Both duties are frozen here; only the dwell count advances.
                    if (step_tick) begin
                        if (dwell_cnt == DWELL_LAST) begin
                            if (zero_mis_l) dir_l <= tdir_q_l;
                            if (zero_mis_r) dir_r <= tdir_q_r;
                            dwell_cnt <= '0;
                            state     <= ST_RAMP;
                        end else begin
                            dwell_cnt <= dwell_cnt + DW'(1);
                        end
                    end
                end
`endif
                ST_BRAKE: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule
